// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control FSM.
// State, ALU, opcode, data-processing cmd and condition-code constants.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [1:0] alu_ctl;
        logic       writes;
        logic       known;
    } dp_dec_t;

    // Unknown cmds fall back to ADD with neither register nor flag write.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d = '{ALU_ADD, 1'b0, 1'b0};
        case (cmd)
            CMD_ADD: d = '{ALU_ADD, 1'b1, 1'b1};
            CMD_SUB: d = '{ALU_SUB, 1'b1, 1'b1};
            CMD_AND: d = '{ALU_AND, 1'b1, 1'b1};
            CMD_ORR: d = '{ALU_ORR, 1'b1, 1'b1};
            CMD_CMP: d = '{ALU_SUB, 1'b0, 1'b1};
            default: d = '{ALU_ADD, 1'b0, 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register, condition evaluator and registered CondExR.
// CondExR is captured at the end of DECODE and held for the instruction.
import mc_pkg::*;

module cond_logic (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic       cond_ld,
    input  logic       flags_ld,
    output logic       condex
);

    logic [3:0] flags;
    logic       n, z, c, v;
    logic       cond_ok;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = !z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = !c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = !n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = !v;
            COND_HI: cond_ok = c && !z;
            COND_LS: cond_ok = !c || z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = !z && (n == v);
            COND_LE: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags  <= 4'b0000;
            condex <= 1'b0;
        end else begin
            if (cond_ld)
                condex <= cond_ok;
            if (flags_ld && condex)
                flags <= aluflags;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle ARM datapath.
// Outputs decode combinationally from State, CondExR and the IR fields.
import mc_pkg::*;

module multicycle_controller (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    state_t  state;
    dp_dec_t dp;
    logic    condex;
    logic    rd_pc;
    logic    in_exec;
    logic    flags_ld;
    logic    pcw, memw, irw, regw;

    assign dp       = dp_decode(Funct[4:1]);
    assign rd_pc    = (Rd == 4'd15);
    assign in_exec  = (state == EXECR) || (state == EXECI);
    // CMP updates flags whenever executed; other known cmds need the S bit.
    assign flags_ld = in_exec &&
                      ((Funct[4:1] == CMD_CMP) || (Funct[0] && dp.known));

    cond_logic u_cond (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .cond     (Cond),
        .aluflags (ALUFlags),
        .cond_ld  (state == DECODE),
        .flags_ld (flags_ld),
        .condex   (condex)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_MEM:  state <= MEMADR;
                        OP_DP:   state <= Funct[5] ? EXECI : EXECR;
                        OP_BR:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                MEMWB:  state <= FETCH;
                MEMWR:  state <= FETCH;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                ALUWB:  state <= FETCH;
                BRANCH: state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcw        = 1'b0;
        AdrSrc     = 1'b0;
        memw       = 1'b0;
        irw        = 1'b0;
        regw       = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = condex;
                pcw       = condex && rd_pc;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memw   = condex;
            end
            EXECR: ALUControl = dp.alu_ctl;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp.alu_ctl;
            end
            ALUWB: begin
                regw = condex && dp.writes;
                pcw  = condex && dp.writes && rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw       = condex;
            end
            default: ;
        endcase
    end

    // Strobes are held off while reset is asserted.
    assign PCWrite  = pcw  && RST_N;
    assign MemWrite = memw && RST_N;
    assign IRWrite  = irw  && RST_N;
    assign RegWrite = regw && RST_N;

    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};
    assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, reset corner cases,
// and random instructions against an instruction-level reference model.
module tb_multicycle_controller;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] Cond = 4'h0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'h00;
    logic [3:0] Rd = 4'h0;
    logic [3:0] ALUFlags = 4'h0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic       ALUSrcA;
    logic [3:0] State;

    always #5 CLK = ~CLK;

    multicycle_controller dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [3:0]  alufl;
        int          len;
        logic [19:0] st;
        logic [19:0] strb;
        logic [1:0]  alu2;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(string nm, logic [31:0] instr,
                                logic [3:0] alufl, int len,
                                logic [19:0] st, logic [19:0] strb,
                                logic [1:0] alu2);
        vec_t v;
        v.nm = nm; v.instr = instr; v.alufl = alufl; v.len = len;
        v.st = st; v.strb = strb; v.alu2 = alu2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic set_instr(input logic [31:0] w);
        Cond  = w[31:28];
        Op    = w[27:26];
        Funct = w[25:20];
        Rd    = w[15:12];
    endtask

    function automatic logic [3:0] strobes();
        return {PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    function automatic logic [19:0] outvec();
        return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
    endfunction

    task automatic run_vec(input vec_t v);
        set_instr(v.instr);
        ALUFlags = v.alufl;
        for (int i = 0; i < v.len; i++) begin
            @(negedge CLK);
            check({v.nm, "/state"}, 32'(State), 32'(v.st[i*4 +: 4]));
            check({v.nm, "/strobes"}, 32'(strobes()), 32'(v.strb[i*4 +: 4]));
            if (i == 2)
                check({v.nm, "/aluctl"}, 32'(ALUControl), 32'(v.alu2));
            @(posedge CLK);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] mflags;

    function automatic logic cond_true(logic [3:0] cc, logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cc == 4'hE) return 1'b1;
        if (cc == 4'hF) return 1'b0;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        // odd codes are the complement of the even code below them
        return base ^ cc[0];
    endfunction

    function automatic void dp_model(logic [3:0] cmd, output logic [1:0] alu,
                                     output logic wr, output logic fl_ok);
        alu = 2'b00; wr = 1'b0; fl_ok = 1'b0;
        if (cmd == 4'b0100) begin alu = 2'b00; wr = 1'b1; fl_ok = 1'b1; end
        if (cmd == 4'b0010) begin alu = 2'b01; wr = 1'b1; fl_ok = 1'b1; end
        if (cmd == 4'b0000) begin alu = 2'b10; wr = 1'b1; fl_ok = 1'b1; end
        if (cmd == 4'b1100) begin alu = 2'b11; wr = 1'b1; fl_ok = 1'b1; end
        if (cmd == 4'b1010) begin alu = 2'b01; wr = 1'b0; fl_ok = 1'b1; end
    endfunction

    function automatic logic [19:0] exp_vec(int s, logic c, logic [1:0] op,
                                            logic [5:0] fn, logic [3:0] rd);
        logic pcw, adr, memw, irw, regw, srca, wr, fl;
        logic [1:0] res, srcb, aluc, dalu;
        pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; srca = 0;
        res = 0; srcb = 0; aluc = 0;
        dp_model(fn[4:1], dalu, wr, fl);
        case (s)
            0: begin irw = 1; pcw = 1; srca = 1; srcb = 2; res = 2; end
            1: begin srca = 1; srcb = 2; res = 2; end
            2: srcb = 1;
            3: adr = 1;
            4: begin res = 1; regw = c; pcw = c && rd == 15; end
            5: begin adr = 1; memw = c; end
            6: aluc = dalu;
            7: begin srcb = 1; aluc = dalu; end
            8: begin regw = c && wr; pcw = c && wr && rd == 15; end
            default: begin srcb = 1; res = 2; pcw = c; end
        endcase
        return {4'(s), pcw, adr, memw, irw, regw, res, srca, srcb,
                op, {op == 2'b01, op == 2'b10}, aluc};
    endfunction

    logic [31:0] w;
    logic        cx, wr_m, fl_m;
    logic [1:0]  alu_m;
    int          seq[$];

    initial begin
        tbl[0]  = mk("ldr",    32'hE5912004, 4'h0, 5, 20'h43210, 20'h1000C, 2'b00);
        tbl[1]  = mk("subs_z", 32'hE2510001, 4'h4, 4, 20'h08710, 20'h0100C, 2'b01);
        tbl[2]  = mk("beq_t",  32'h0A000002, 4'h0, 3, 20'h00910, 20'h0080C, 2'b00);
        tbl[3]  = mk("subs_nz",32'hE2510001, 4'h0, 4, 20'h08710, 20'h0100C, 2'b01);
        tbl[4]  = mk("beq_nt", 32'h0A000002, 4'h0, 3, 20'h00910, 20'h0000C, 2'b00);
        tbl[5]  = mk("cmp",    32'hE1500001, 4'h4, 4, 20'h08610, 20'h0000C, 2'b01);
        tbl[6]  = mk("beq_cmp",32'h0A000002, 4'h0, 3, 20'h00910, 20'h0080C, 2'b00);
        tbl[7]  = mk("str",    32'hE5812000, 4'h0, 4, 20'h05210, 20'h0200C, 2'b00);
        tbl[8]  = mk("undef",  32'hEC000000, 4'h0, 2, 20'h00010, 20'h0000C, 2'b00);
        tbl[9]  = mk("str_nv", 32'hF5812000, 4'h0, 4, 20'h05210, 20'h0000C, 2'b00);
        tbl[10] = mk("add_pc", 32'hE280F004, 4'h0, 4, 20'h08710, 20'h0900C, 2'b00);
        tbl[11] = mk("eors",   32'hE0300001, 4'h0, 4, 20'h08610, 20'h0000C, 2'b00);
        tbl[12] = mk("bne_nt", 32'h1A000000, 4'h0, 3, 20'h00910, 20'h0000C, 2'b00);
        tbl[13] = mk("ldr_pc", 32'hE591F004, 4'h0, 5, 20'h43210, 20'h9000C, 2'b00);

        // reset held for three cycles
        set_instr(32'hEC000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst/state", 32'(State), 32'd0);
            check("rst/strobes", 32'(strobes()), 32'h0);
        end
        check("rst/fetch_dec",
              32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}),
              32'({1'b0, 2'b10, 1'b1, 2'b10, 2'b00}));
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst/strobes", 32'(strobes()), 32'hC);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("post_rst/decode", 32'(State), 32'd1);
        @(posedge CLK);
        #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // flags to 1111, then abandon a STR with reset during MEMADR
        run_vec(mk("adds", 32'hE2900000, 4'hF, 4, 20'h08710, 20'h0100C, 2'b00));
        run_vec(mk("beq_f", 32'h0A000000, 4'h0, 3, 20'h00910, 20'h0080C, 2'b00));
        set_instr(32'hE5812000);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("str_rst/memadr", 32'(State), 32'd2);
        check("str_rst/memw_pre", 32'(MemWrite), 32'd0);
        #1 RST_N = 1'b0;
        #1;
        check("str_rst/state", 32'(State), 32'd0);
        check("str_rst/strobes", 32'(strobes()), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        check("str_rst/held", 32'({State, MemWrite}), 32'h0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        run_vec(mk("beq_clr", 32'h0A000000, 4'h0, 3, 20'h00910, 20'h0000C, 2'b00));
        run_vec(mk("bpl_clr", 32'h5A000000, 4'h0, 3, 20'h00910, 20'h0080C, 2'b00));
        mflags = 4'h0;

        // random instructions against the model
        repeat (300) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
            if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
            set_instr(w);
            cx = cond_true(w[31:28], mflags);
            dp_model(w[24:21], alu_m, wr_m, fl_m);
            seq = {0, 1};
            case (w[27:26])
                2'b01:   seq = w[20] ? {0, 1, 2, 3, 4} : {0, 1, 2, 5};
                2'b00:   seq = w[25] ? {0, 1, 7, 8} : {0, 1, 6, 8};
                2'b10:   seq = {0, 1, 9};
                default: seq = {0, 1};
            endcase
            foreach (seq[k]) begin
                ALUFlags = 4'($urandom);
                @(negedge CLK);
                check("rand", 32'(outvec()),
                      32'(exp_vec(seq[k], cx, w[27:26], w[25:20], w[15:12])));
                if ((seq[k] == 6 || seq[k] == 7) && cx &&
                    (w[24:21] == 4'b1010 || (w[20] && fl_m)))
                    mflags = ALUFlags;
                @(posedge CLK);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the shared-memory, multicycle ARM datapath, replacing the single-cycle control unit. Each instruction is executed over 2–5 clocks. The block latches the NZCV flags and evaluates the condition field. It then drives the per-state strobes and mux selects for PC, instruction register, memory, register file and ALU.

## Interface
Parameters: none.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, combinational in the same cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  {Op==01, Op==10}
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- State  out  4  current state encoding, for debug

## Operation
States and encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Encodings 10–15 are illegal and go to FETCH on the next clock.

Transitions:
- FETCH→DECODE.
- DECODE dispatches on Op:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECR
  - Op=00 with Funct[5]=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH (undefined instruction; no side effects)
- MEMADR→MEMRD if Funct[0]=1, else MEMWR.
- MEMRD→MEMWB→FETCH.
- MEMWR→FETCH.
- EXECR/EXECI→ALUWB→FETCH.
- BRANCH→FETCH.

Outputs per state. Anything not listed is 0. ALUControl is ADD unless stated.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=CondExR. If Rd=15, also PCWrite=CondExR.
- MEMWR: AdrSrc=1, MemWrite=CondExR.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd.
- ALUWB: ResultSrc=00, RegWrite=CondExR & writes(cmd). If Rd=15, also PCWrite=CondExR & writes(cmd).
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondExR.

Data-processing decode (cmd = Funct[4:1]):
- 0100 → ADD
- 0010 → SUB
- 0000 → AND
- 1100 → ORR
- 1010 (CMP) → SUB, with no register write
- Any other cmd → ADD, with no register write and no flag write.

Condition evaluation:
- CondExR is registered at the end of DECODE from Cond and the stored flags.
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL (1110) is always true. 1111 is never executed.

Flags register:
- Loads ALUFlags on the clock edge that ends EXECR or EXECI.
- Load condition: Funct[0]=1 (S bit), CondExR=1, and cmd is one of the five decoded cmds.
- For CMP (cmd 1010), flags are always written when CondExR=1, regardless of the S bit.

## Timing
Cycles per instruction (CPI):
- LDR 5, STR 4, data-processing 4, B 3, undefined 2.

Reset:
- While RST_N=0:
  - State=FETCH, flags=0000, CondExR=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs take the FETCH decode.
- The first IRWrite/PCWrite pulse occurs in the first cycle after RST_N deasserts. That pulse is sampled at the first rising edge after deassertion.

Reset mid-instruction:
- The instruction is abandoned and no strobe completes.
- The flags are cleared.

Output and input behaviour:
- All outputs are combinational from State, CondExR, Funct, Op and Rd. There is no output register.
- Cond, Op, Funct and Rd come from the instruction register and must be stable from DECODE through the last state of the instruction.

## Structure
Package `mc_pkg` holds:
- the state enum and encodings,
- the ALUControl codes,
- the Op codes,
- the cmd codes,
- the condition-code constants.

Sub-module `cond_logic` holds:
- the flags register,
- CondExR,
- the condition evaluator.

`multicycle_controller` holds the next-state logic and the output decode.

## Test plan
1. Reset low for 3 cycles, then release → State=0; no strobes during reset; IRWrite=1 and PCWrite=1 in the first post-reset cycle; DECODE follows.
2. Instruction 0xE5912004 (LDR, AL) → states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; AdrSrc=1 in MEMRD.
3. Instruction 0xE2510001 (SUBS, imm) with ALUFlags=0100 in EXECI → ALUControl=01; flags become Z=1; RegWrite in ALUWB.
4. After test 3, instruction 0x0A000002 (BEQ) → PCWrite=1 in BRANCH. Repeat with Z=0 → PCWrite=0; sequence is still 0,1,9,0.
5. Instruction 0xE1500001 (CMP) → RegWrite=0 in ALUWB; flags are updated.
6. Instruction 0xE5812000 (STR) with RST_N pulsed low in MEMADR → returns to FETCH; MemWrite is never asserted; flags are cleared.
